// File: rtl/multi_wave_generator_if.sv
// ---------------------------------------------------------------------------
// multi_wave_generator_if
//
// Configuration handshake bundle for multi_wave_generator.
//
// Signals:
//   cfg_valid  master -> slave  a new configuration is offered
//   cfg_ready  slave  -> master the generator can take a configuration
//   cfg_mode   master -> slave  waveform select (0 sine, 1 cosine, 2 full-rect,
//                               3 half-rect, 4 square, 5..7 reserved)
//   cfg_shift  master -> slave  frequency shift (0..1 are clamped to 2)
//
// Modports:
//   master  the configuration source (e.g. register block or testbench)
//   slave   the generator
// ---------------------------------------------------------------------------
interface multi_wave_generator_if;
   logic       cfg_valid;
   logic       cfg_ready;
   logic [2:0] cfg_mode;
   logic [3:0] cfg_shift;

   modport master (
      output cfg_valid,
      output cfg_mode,
      output cfg_shift,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_mode,
      input  cfg_shift,
      output cfg_ready
   );
endinterface

// File: rtl/multi_wave_generator.sv
// ---------------------------------------------------------------------------
// multi_wave_generator
//
// Coupled sine/cosine oscillator with a programmable frequency shift and one
// runtime-selectable output waveform. The oscillator advances one step per
// cycle with en=1:
//     s' = s + (c >>> k)
//     c' = c - (s' >>> k)      (uses the freshly updated s')
// which is an area-preserving shear, so the orbit stays bounded and its
// angular step is roughly 2^-k radians.
//
// New mode/shift settings are taken through a valid/ready handshake into a
// single pending slot and only become active on the step that produces a
// positive-going zero crossing of the sine, so the selected waveform never
// changes shape part-way through a cycle.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst           synchronous active-high reset
//   en            advance the oscillator by one step this cycle
//   cfg           configuration handshake (slave side)
//   wave_out      selected waveform, unsigned, OUT_WIDTH bits
//   sin_out       signed sine state
//   cos_out       signed cosine state
//   zero_cross    one-cycle pulse when the sine goes negative -> non-negative
//   period_count  enabled steps in the last completed period (saturating)
// ---------------------------------------------------------------------------
module multi_wave_generator #(
   parameter int WIDTH       = 16,
   parameter int OUT_WIDTH   = 8,
   parameter int COS_INIT    = 30000,
   parameter int RESET_SHIFT = 6
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        en,
   multi_wave_generator_if.slave       cfg,
   output logic [OUT_WIDTH-1:0]        wave_out,
   output logic signed [WIDTH-1:0]     sin_out,
   output logic signed [WIDTH-1:0]     cos_out,
   output logic                        zero_cross,
   output logic [15:0]                 period_count
);

   // ------------------------------------------------------------------------
   // Waveform selection codes
   // ------------------------------------------------------------------------
   typedef enum logic [2:0] {
      MODE_SINE   = 3'd0,
      MODE_COS    = 3'd1,
      MODE_FULL   = 3'd2,
      MODE_HALF   = 3'd3,
      MODE_SQUARE = 3'd4
   } mode_t;

   localparam logic signed [WIDTH-1:0] COS_INIT_S = WIDTH'(COS_INIT);
   localparam logic signed [WIDTH-1:0] MOST_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH-1:0] MAX_POS    = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [OUT_WIDTH-1:0]    MID        = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [3:0]              SHIFT_RST  = 4'(RESET_SHIFT);
   localparam logic [3:0]              SHIFT_MIN  = 4'd2;
   localparam int                      DROP_BITS  = WIDTH - OUT_WIDTH;

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic signed [WIDTH-1:0] sin_reg;
   logic signed [WIDTH-1:0] cos_reg;
   logic [OUT_WIDTH-1:0]    wave_reg;
   logic                    zero_cross_reg;
   logic [15:0]             period_reg;
   logic [15:0]             count_reg;

   mode_t                   mode_active_reg;
   logic [3:0]              shift_active_reg;

   logic                    pend_valid_reg;
   mode_t                   pend_mode_reg;
   logic [3:0]              pend_shift_reg;

   // ------------------------------------------------------------------------
   // Next-step oscillator values
   // ------------------------------------------------------------------------
   logic signed [WIDTH-1:0] sin_next;
   logic signed [WIDTH-1:0] cos_next;
   logic                    crossing;

   always_comb begin
      sin_next = sin_reg + (cos_reg >>> shift_active_reg);
      cos_next = cos_reg - (sin_next >>> shift_active_reg);
      // Sign bit falling from 1 to 0 marks a negative -> non-negative step.
      crossing = sin_reg[WIDTH-1] & ~sin_next[WIDTH-1];
   end

   // ------------------------------------------------------------------------
   // Waveform shaping from the post-step values, so wave_out is registered
   // on the same edge as sin_out/cos_out and always agrees with them.
   // ------------------------------------------------------------------------
   logic signed [WIDTH-1:0] abs_sin;
   logic [OUT_WIDTH-1:0]    top_sin;
   logic [OUT_WIDTH-1:0]    top_cos;
   logic [OUT_WIDTH-1:0]    top_abs;
   logic [OUT_WIDTH-1:0]    square_bits;
   logic [OUT_WIDTH-1:0]    wave_next;

   always_comb begin
      // Negating the most negative value would wrap back to itself, so it is
      // pinned to the largest positive value instead.
      if (!sin_next[WIDTH-1]) begin
         abs_sin = sin_next;
      end else if (sin_next == MOST_NEG) begin
         abs_sin = MAX_POS;
      end else begin
         abs_sin = -sin_next;
      end

      top_sin = OUT_WIDTH'(sin_next >>> DROP_BITS);
      top_cos = OUT_WIDTH'(cos_next >>> DROP_BITS);
      top_abs = OUT_WIDTH'(abs_sin  >>> DROP_BITS);
   end

   // Square wave: every output bit follows the inverted sign of the sine.
   for (genvar gi = 0; gi < OUT_WIDTH; gi++) begin : g_square
      assign square_bits[gi] = ~sin_next[WIDTH-1];
   end

   always_comb begin
      wave_next = MID;
      case (mode_active_reg)
         // Flipping the MSB of a two's complement value adds the midpoint,
         // giving an offset-binary, monotonic 0..2M-1 code.
         MODE_SINE:   wave_next = top_sin ^ MID;
         MODE_COS:    wave_next = top_cos ^ MID;
         MODE_FULL:   wave_next = top_abs;
         MODE_HALF:   wave_next = sin_next[WIDTH-1] ? '0 : top_sin;
         MODE_SQUARE: wave_next = square_bits;
         default:     wave_next = MID;
      endcase
   end

   // ------------------------------------------------------------------------
   // Period counter helper: saturates instead of wrapping so that a stalled
   // or extremely slow oscillator reads as "at least 65535 steps".
   // ------------------------------------------------------------------------
   logic [15:0] count_inc;

   always_comb begin
      count_inc = (count_reg == 16'hFFFF) ? count_reg : count_reg + 16'd1;
   end

   // ------------------------------------------------------------------------
   // Configuration handshake
   // ------------------------------------------------------------------------
   logic       cfg_ready_int;
   logic       accept;
   logic       apply;
   logic [3:0] shift_clamped;

   always_comb begin
      // Only one pending slot; ready re-opens the cycle after it is applied.
      cfg_ready_int = ~pend_valid_reg & ~rst;
      accept        = cfg.cfg_valid & cfg_ready_int;
      // Shifts below 2 would make the recurrence step too coarse to stay a
      // well-behaved oscillator, so they are raised to 2.
      shift_clamped = (cfg.cfg_shift < SHIFT_MIN) ? SHIFT_MIN : cfg.cfg_shift;
      // Settings change only on the step that produces a crossing.
      apply         = en & crossing & pend_valid_reg;
   end

   assign cfg.cfg_ready = cfg_ready_int;

   // ------------------------------------------------------------------------
   // Sequential update
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         sin_reg          <= '0;
         cos_reg          <= COS_INIT_S;
         wave_reg         <= MID;
         zero_cross_reg   <= 1'b0;
         period_reg       <= '0;
         count_reg        <= '0;
         mode_active_reg  <= MODE_SINE;
         shift_active_reg <= SHIFT_RST;
         pend_valid_reg   <= 1'b0;
         pend_mode_reg    <= MODE_SINE;
         pend_shift_reg   <= '0;
      end else begin
         if (en) begin
            sin_reg        <= sin_next;
            cos_reg        <= cos_next;
            // wave uses the mode active before this edge, even on an apply
            // edge; the new mode shows up from the following step.
            wave_reg       <= wave_next;
            zero_cross_reg <= crossing;
            if (crossing) begin
               // This step itself belongs to the period that just closed.
               period_reg <= count_inc;
               count_reg  <= '0;
            end else begin
               count_reg  <= count_inc;
            end
         end else begin
            zero_cross_reg <= 1'b0;
         end

         // accept and apply are mutually exclusive: accept needs an empty
         // slot, apply needs a full one.
         if (apply) begin
            mode_active_reg  <= pend_mode_reg;
            shift_active_reg <= pend_shift_reg;
            pend_valid_reg   <= 1'b0;
         end else if (accept) begin
            pend_valid_reg   <= 1'b1;
            pend_mode_reg    <= mode_t'(cfg.cfg_mode);
            pend_shift_reg   <= shift_clamped;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign sin_out      = sin_reg;
   assign cos_out      = cos_reg;
   assign wave_out     = wave_reg;
   assign zero_cross   = zero_cross_reg;
   assign period_count = period_reg;

endmodule

// File: tb/tb_multi_wave_generator.sv
// ---------------------------------------------------------------------------
// tb_multi_wave_generator
//
// Directed bench for multi_wave_generator with a behavioural integer model.
// The model tracks the oscillator with plain int arithmetic (explicit modulo
// 2^16 wrap, floor division via shifts on int), the waveform as offset /
// rectified values of that integer, and the pending/active configuration.
// A negedge process compares every DUT output against the model each cycle;
// directed sections add literal expectations from hand calculation.
// ---------------------------------------------------------------------------
module tb_multi_wave_generator;

   localparam int W  = 16;
   localparam int OW = 8;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 en;
   logic [OW-1:0]        wave_out;
   logic signed [W-1:0]  sin_out;
   logic signed [W-1:0]  cos_out;
   logic                 zero_cross;
   logic [15:0]          period_count;

   multi_wave_generator_if bus();

   multi_wave_generator #(
      .WIDTH      (16),
      .OUT_WIDTH  (8),
      .COS_INIT   (30000),
      .RESET_SHIFT(6)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .cfg         (bus),
      .wave_out    (wave_out),
      .sin_out     (sin_out),
      .cos_out     (cos_out),
      .zero_cross  (zero_cross),
      .period_count(period_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   // Model state
   int m_s, m_c, m_wave, m_zc, m_per, m_cnt;
   int m_mode, m_shift, m_pend, m_pmode, m_pshift;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int wrap16(input int x);
      int y;
      y = x & 32'h0000FFFF;
      if (y >= 32768) y = y - 65536;
      return y;
   endfunction

   function automatic int sat16(input int x);
      return (x > 65535) ? 65535 : x;
   endfunction

   function automatic int wave_of(input int mode, input int s, input int c);
      int a;
      case (mode)
         0: return (s >>> 8) + 128;
         1: return (c >>> 8) + 128;
         2: begin
            a = (s < 0) ? -s : s;
            if (a > 32767) a = 32767;
            return a >>> 8;
         end
         3: return (s >= 0) ? (s >>> 8) : 0;
         4: return (s >= 0) ? 255 : 0;
         default: return 128;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs currently driven.
   task automatic model_step();
      int s1, c1;
      bit acc;
      if (rst) begin
         m_s = 0; m_c = 30000; m_wave = 128; m_zc = 0; m_per = 0; m_cnt = 0;
         m_mode = 0; m_shift = 6; m_pend = 0; m_pmode = 0; m_pshift = 0;
      end else begin
         acc = bus.cfg_valid && (m_pend == 0);
         if (en) begin
            s1 = wrap16(m_s + (m_c >>> m_shift));
            c1 = wrap16(m_c - (s1 >>> m_shift));
            m_wave = wave_of(m_mode, s1, c1);
            if (m_s < 0 && s1 >= 0) begin
               m_zc  = 1;
               m_per = sat16(m_cnt + 1);
               m_cnt = 0;
               if (m_pend != 0) begin
                  m_mode  = m_pmode;
                  m_shift = m_pshift;
                  m_pend  = 0;
               end
            end else begin
               m_zc  = 0;
               m_cnt = sat16(m_cnt + 1);
            end
            m_s = s1;
            m_c = c1;
         end else begin
            m_zc = 0;
         end
         if (acc) begin
            m_pend   = 1;
            m_pmode  = int'(bus.cfg_mode);
            m_pshift = (bus.cfg_shift < 4'd2) ? 2 : int'(bus.cfg_shift);
         end
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_on) begin
         chk("sin_out",      int'(sin_out),       m_s);
         chk("cos_out",      int'(cos_out),       m_c);
         chk("wave_out",     int'(wave_out),      m_wave);
         chk("zero_cross",   int'(zero_cross),    m_zc);
         chk("period_count", int'(period_count),  m_per);
         chk("cfg_ready",    int'(bus.cfg_ready), (m_pend == 0 && rst == 1'b0) ? 1 : 0);
      end
   end

   task automatic tick(input logic r, input logic e, input logic v, input int md, input int sh);
      rst           = r;
      en            = e;
      bus.cfg_valid = v;
      bus.cfg_mode  = 3'(md);
      bus.cfg_shift = 4'(sh);
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   task automatic run_until_cross(input int budget, input string tag);
      int n;
      n = 0;
      do begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         n++;
      end while (!zero_cross && n < budget);
      if (!zero_cross) chk(tag, 0, 1);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_sin"},   int'(sin_out),       0);
      chk({tag, "_cos"},   int'(cos_out),       30000);
      chk({tag, "_wave"},  int'(wave_out),      128);
      chk({tag, "_zc"},    int'(zero_cross),    0);
      chk({tag, "_per"},   int'(period_count),  0);
      chk({tag, "_ready"}, int'(bus.cfg_ready), 0);
   endtask

   task automatic check_first_step(input string tag);
      chk({tag, "_sin"},  int'(sin_out),  468);
      chk({tag, "_cos"},  int'(cos_out),  29993);
      chk({tag, "_wave"}, int'(wave_out), 129);
   endtask

   initial begin
      int ncross;
      int n;

      rst = 1'b1; en = 1'b0;
      bus.cfg_valid = 1'b0; bus.cfg_mode = 3'd0; bus.cfg_shift = 4'd0;

      // ---- Reset and first step -------------------------------------------
      tick(1'b1, 1'b0, 1'b0, 0, 0);
      chk_on = 1'b1;
      tick(1'b1, 1'b0, 1'b0, 0, 0);
      check_reset_values("reset");
      tick(1'b0, 1'b0, 1'b0, 0, 0);
      chk("ready_after_reset", int'(bus.cfg_ready), 1);
      tick(1'b0, 1'b1, 1'b0, 0, 0);
      check_first_step("first_step");

      // ---- Free run at shift 6 --------------------------------------------
      ncross = 0;
      for (int i = 0; i < 1999; i++) begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         if (zero_cross) begin
            ncross++;
            if (ncross >= 2)
               chk("period_shift6", (period_count >= 401 && period_count <= 403) ? 1 : 0, 1);
         end
      end
      chk("crossings_in_2000", (ncross >= 4) ? 1 : 0, 1);

      // ---- Mode 2 / shift 5 offered in the negative half ------------------
      n = 0;
      while (!(sin_out < 0) && n < 600) begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         n++;
      end
      if (!(sin_out < 0)) chk("wait_negative", 0, 1);
      for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b0, 0, 0);
      tick(1'b0, 1'b1, 1'b1, 2, 5);
      chk("ready_drop", int'(bus.cfg_ready), 0);
      run_until_cross(500, "timeout_mode2_apply");
      chk("ready_reopen", int'(bus.cfg_ready), 1);
      ncross = 0;
      n = 0;
      while (ncross < 3 && n < 1000) begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         n++;
         chk("full_rect_max", (wave_out <= 8'd127) ? 1 : 0, 1);
         if (zero_cross) begin
            ncross++;
            if (ncross >= 2)
               chk("period_shift5", (period_count >= 200 && period_count <= 203) ? 1 : 0, 1);
         end
      end
      if (ncross < 3) chk("timeout_mode2_periods", 0, 1);

      // ---- Back-to-back offers: mode 3 accepted, mode 4 held off ----------
      tick(1'b0, 1'b1, 1'b1, 3, 5);
      for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b1, 4, 5);
      run_until_cross(1000, "timeout_mode3_apply");
      for (int i = 0; i < 250; i++) begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         if (sin_out < 0) chk("half_rect_neg", int'(wave_out), 0);
         else             chk("half_rect_pos", int'(wave_out), int'(sin_out) >>> 8);
      end

      // ---- Mode 4 square --------------------------------------------------
      tick(1'b0, 1'b1, 1'b1, 4, 5);
      run_until_cross(1000, "timeout_mode4_apply");
      for (int i = 0; i < 250; i++) begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         chk("square", int'(wave_out), (sin_out < 0) ? 0 : 255);
      end

      // ---- Reserved mode 5 ------------------------------------------------
      tick(1'b0, 1'b1, 1'b1, 5, 5);
      run_until_cross(1000, "timeout_mode5_apply");
      for (int i = 0; i < 50; i++) begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         if (i % 10 == 0) chk("reserved_mid", int'(wave_out), 128);
      end

      // ---- Shift 0 clamps to 2, long run ----------------------------------
      tick(1'b0, 1'b1, 1'b1, 0, 0);
      run_until_cross(1000, "timeout_shift0_apply");
      for (int i = 0; i < 10000; i++) begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         if (i % 1000 == 999)
            chk("bounded", (sin_out > -32000 && sin_out < 32000) ? 1 : 0, 1);
      end

      // ---- Reset with a config pending and en toggling --------------------
      tick(1'b0, 1'b1, 1'b1, 2, 3);
      chk("pending_ready", int'(bus.cfg_ready), 0);
      for (int i = 0; i < 6; i++) tick(1'b0, (i % 2 == 0) ? 1'b0 : 1'b1, 1'b0, 0, 0);
      tick(1'b1, 1'b1, 1'b1, 4, 7);
      check_reset_values("midreset");
      tick(1'b0, 1'b0, 1'b0, 0, 0);
      chk("midreset_ready", int'(bus.cfg_ready), 1);
      tick(1'b0, 1'b1, 1'b0, 0, 0);
      check_first_step("midreset_first");
      ncross = 0;
      for (int i = 0; i < 900; i++) begin
         tick(1'b0, 1'b1, 1'b0, 0, 0);
         if (zero_cross) begin
            ncross++;
            chk("midreset_mode0", (int'(wave_out) >= 128) ? 1 : 0, 1);
            if (ncross >= 2)
               chk("midreset_period", (period_count >= 401 && period_count <= 403) ? 1 : 0, 1);
         end
      end

      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
